// File: rtl/keccak_pkg.sv
// keccak_scheduler shared types and helpers.
// Holds the FSM encoding, default latency and the nonce-insert function.
package keccak_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int HASH_LATENCY_DEF = 74;
  localparam int NONCE_WORD_DEF   = 0;

  // Word k occupies bits [511-64k -: 64], i.e. a left shift of 448-64k.
  function automatic logic [511:0] insert_nonce(
    input logic [511:0] hdr,
    input int           idx,
    input logic [63:0]  nonce
  );
    logic [8:0]   sh;
    logic [511:0] mask;
    sh   = 9'(448 - 64 * idx);
    mask = {448'b0, {64{1'b1}}} << sh;
    return (hdr & ~mask) | ({448'b0, nonce} << sh);
  endfunction

endpackage

// File: rtl/valid_delay.sv
// In-flight tracker for the keccak core: one bit per pipeline slot.
// o_any reports bits still in flight behind the current tail.
module valid_delay #(
  parameter int DEPTH = 74
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_in,
  output logic o_tail,
  output logic o_any
);

  logic [DEPTH-1:0] r_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= '0;
    end else if (i_clr) begin
      r_line <= '0;
    end else begin
      r_line <= {r_line[DEPTH-2:0], i_in};
    end
  end

  assign o_tail = r_line[DEPTH-1];
  assign o_any  = |r_line[DEPTH-2:0];

endmodule

// File: rtl/keccak_scheduler.sv
// Job sequencer for the pipelined keccak512 core: issues nonces,
// tracks in-flight hashes and hands qualifying nonces to the host.
module keccak_scheduler
  import keccak_pkg::*;
#(
  parameter int HASH_LATENCY = HASH_LATENCY_DEF,
  parameter int NONCE_WORD   = NONCE_WORD_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [511:0] header,
  input  logic [63:0]  start_nonce,
  input  logic [63:0]  end_nonce,
  input  logic [63:0]  target,
  output logic [511:0] core_data,
  input  logic [511:0] core_hash,
  output logic         busy,
  output logic         done,
  output logic         gold_valid,
  input  logic         gold_ready,
  output logic [63:0]  gold_nonce,
  output logic [63:0]  gold_word,
  output logic [63:0]  hashes_done,
  output logic [15:0]  dropped
);

  state_t r_state;
  state_t w_next;

  logic [511:0] r_hdr;
  logic [511:0] r_core_data;
  logic [63:0]  r_end;
  logic [63:0]  r_target;
  logic [63:0]  r_issue;
  logic [63:0]  r_ret;
  logic [63:0]  r_hashes;
  logic [15:0]  r_dropped;
  logic         r_gold_valid;
  logic [63:0]  r_gold_nonce;
  logic [63:0]  r_gold_word;

  logic w_tail;
  logic w_any;
  logic w_push;
  logic w_last;
  logic w_accept;
  logic w_ret;
  logic w_found;
  logic w_load;
  logic w_unused_hash;

  assign w_last   = (r_issue == r_end);
  assign w_push   = (r_state == S_RUN);
  assign w_accept = start & ~abort &
                    ((r_state == S_IDLE) | (r_state == S_DONE));
  // An abort also discards whatever reaches the tail that cycle.
  assign w_ret    = w_tail & ~abort;
  assign w_found  = w_ret & (core_hash[63:0] <= r_target);
  assign w_load   = w_found & (~r_gold_valid | gold_ready);

  assign w_unused_hash = ^core_hash[511:64];

  valid_delay #(
    .DEPTH (HASH_LATENCY)
  ) u_vline (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (abort),
    .i_in   (w_push),
    .o_tail (w_tail),
    .o_any  (w_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_RUN;
      S_RUN:          if (w_last) w_next = S_DRAIN;
      S_DRAIN:        if (!w_any) w_next = S_DONE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdr       <= '0;
      r_core_data <= '0;
      r_end       <= '0;
      r_target    <= '0;
      r_issue     <= '0;
      r_ret       <= '0;
      r_hashes    <= '0;
      r_dropped   <= '0;
    end else if (w_accept) begin
      r_hdr       <= header;
      r_end       <= end_nonce;
      r_target    <= target;
      r_issue     <= start_nonce;
      r_ret       <= start_nonce;
      r_hashes    <= '0;
      r_dropped   <= '0;
      r_core_data <= insert_nonce(header, NONCE_WORD, start_nonce);
    end else begin
      if (w_push && !abort && !w_last) begin
        r_issue     <= r_issue + 64'd1;
        r_core_data <= insert_nonce(r_hdr, NONCE_WORD,
                                    r_issue + 64'd1);
      end
      if (w_ret) begin
        r_hashes <= r_hashes + 64'd1;
        r_ret    <= r_ret + 64'd1;
      end
      if (w_found && !w_load && (r_dropped != 16'hFFFF)) begin
        r_dropped <= r_dropped + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gold_valid <= 1'b0;
      r_gold_nonce <= '0;
      r_gold_word  <= '0;
    end else if (w_load) begin
      r_gold_valid <= 1'b1;
      r_gold_nonce <= r_ret;
      r_gold_word  <= core_hash[63:0];
    end else if (r_gold_valid && gold_ready) begin
      r_gold_valid <= 1'b0;
    end
  end

  assign core_data   = r_core_data;
  assign busy        = (r_state == S_RUN) | (r_state == S_DRAIN);
  assign done        = (r_state == S_DONE);
  assign gold_valid  = r_gold_valid;
  assign gold_nonce  = r_gold_nonce;
  assign gold_word   = r_gold_word;
  assign hashes_done = r_hashes;
  assign dropped     = r_dropped;

endmodule

// File: doc/keccak_scheduler.md
# keccak_scheduler

Work sequencer for the fully pipelined keccak512 hash core. Accepts a job (512-bit header, inclusive nonce range, 64-bit target), issues one header per cycle into the core with the nonce substituted, and tracks in-flight hashes with a valid delay line. It compares each emerging hash against the target and hands qualifying nonces to the host through a one-entry valid/ready holding register. It sits between the host/job interface and the keccak512 instance.

## Interface
- HASH_LATENCY, 74, cycles from core_data presented to the matching core_hash (core has no valid or reset)
- NONCE_WORD, 0, index 0..7 of the 64-bit header word replaced by the nonce; word k = bits [511-64k -: 64]
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  job start strobe; honoured only in IDLE or DONE
- abort  in  1  cancel job; honoured in any state
- header  in  512  job header, sampled on accepted start
- start_nonce  in  64  first nonce, sampled on start
- end_nonce  in  64  last nonce (inclusive), sampled on start
- target  in  64  threshold, sampled on start
- core_data  out  512  to hash core data input
- core_hash  in  512  from hash core hash output
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE
- gold_valid  out  1  gold register holds a result
- gold_ready  in  1  host accepts gold result
- gold_nonce  out  64  qualifying nonce
- gold_word  out  64  compared hash word (core_hash[63:0])
- hashes_done  out  64  count of hashes retired for the current job
- dropped  out  16  results lost because gold register full, saturating

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset -> IDLE.
- IDLE/DONE + start (abort low): latch job, issue_nonce <= start_nonce, ret_nonce <= start_nonce, hashes_done <= 0, dropped <= 0 -> RUN.
- RUN: every cycle core_data = header with word NONCE_WORD = issue_nonce; push 1 into valid line; if issue_nonce == end_nonce -> DRAIN, else issue_nonce += 1 (mod 2^64; wrap past 2^64-1 to 0 allowed, end < start is legal).
- DRAIN: push 0; core_data holds last value; when valid line empty -> DONE.
- abort: -> IDLE next cycle, valid line cleared, no further retirements; gold register and counters retained. abort with start same cycle: abort wins.
- Retirement (valid line output = 1): hashes_done += 1, ret_nonce += 1; found = core_hash[63:0] <= target (unsigned).
- Gold register: found and (empty or gold_ready same cycle) -> load ret_nonce, core_hash[63:0]; found while full and gold_ready low -> dropped += 1, saturate at 16'hFFFF. Pop: gold_valid & gold_ready clears unless reloaded same cycle.
- start_nonce == end_nonce: exactly one hash issued.

## Timing
- Reset values: core_data 0, busy 0, done 0, gold_valid 0, gold_nonce 0, gold_word 0, hashes_done 0, dropped 0; valid line all 0.
- start accepted at edge of cycle 0; first nonce on core_data in cycle 1 (registered).
- Issue in cycle c retires in cycle c+HASH_LATENCY; gold_valid asserts in cycle c+HASH_LATENCY+1.
- N-nonce job: busy high cycles 1..N+HASH_LATENCY; done high from cycle N+HASH_LATENCY+1 until next start/abort.
- gold_valid stays high and gold_nonce/gold_word stable until handshake.
- Throughput: one hash per cycle in RUN, no bubbles.

## Structure
- Package keccak_pkg: state enum, HASH_LATENCY default, NONCE_WORD default, nonce-insert function (header, word index, nonce -> 512-bit data).
- Sub-module valid_delay: 1-bit shift register, depth HASH_LATENCY, synchronous clear (abort) plus async reset, outputs tail bit and an any-valid flag for DRAIN exit.

## Test plan
- Job start=0x10, end=0x13, target=2^64-1 -> 4 golds, nonces 0x10..0x13 in order (gold_ready held high), hashes_done=4, done at cycle 4+74+1.
- Target=0 with core model forcing hash word 0 only for nonce 0x22 in range 0x20..0x2F -> single gold nonce 0x22, gold_word 0, dropped=0.
- Range 0xFFFFFFFFFFFFFFFE..0x1 -> 4 hashes, nonces FE, FF, 0, 1 retire in order.
- All-qualifying job of 10 nonces, gold_ready low -> gold_nonce = first nonce, dropped=9; raise gold_ready -> one pop, gold_valid falls.
- abort in cycle 20 of 100-nonce job -> IDLE next cycle, busy 0, hashes_done frozen, no retirements afterwards; start ignored while RUN.
- rst_n low mid-DRAIN -> all outputs 0 immediately, valid line empty, state IDLE.
